stall_ctrl: RTL

- Hazard scheduler for the 5-stage MIPS pipeline.
- Sits beside the fetch stage and the D/E pipeline registers.
- Owns a shadow copy of the destination register and Tnew of the instructions in E and M, plus the busy timer of the shared mult/div unit.
- Decides each cycle whether the instruction in D may issue, or whether the fetch PC and the D register hold (pause) while a bubble is injected into E.

---
 rtl/stall_ctrl_if.sv | 32 +++
 rtl/stall_ctrl.sv | 78 +++++++
 2 files changed

// File: rtl/stall_ctrl_if.sv
// rtl/stall_ctrl_if.sv - decode-stage hazard request and stall response bundle
interface stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       D_rs;
    logic [4:0]       D_rt;
    logic [1:0]       D_rs_tuse;
    logic [1:0]       D_rt_tuse;
    logic [4:0]       D_dst;
    logic [1:0]       D_tnew;
    logic             D_md_start;
    logic             D_md_div;
    logic             D_md_use;
    logic             pause;
    logic             E_flush;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    // Decode side: presents the instruction in D, receives the stall decision
    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew,
               D_md_start, D_md_div, D_md_use,
        input  pause, E_flush, md_busy, stall_cnt
    );

    // Scheduler side
    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew,
               D_md_start, D_md_div, D_md_use,
        output pause, E_flush, md_busy, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - issue/stall scheduler for the 5-stage pipeline
module stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    stall_ctrl_if.slave   hz
);
    localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    // Shadow of the producers sitting in E and M; W is covered by the
    // register file writing before it is read.
    logic [4:0]       e_dst_q,  e_dst_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       m_dst_q,  m_dst_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic haz_rs_e, haz_rt_e, haz_rs_m, haz_rt_m, haz_md, stall;

    // Hazard detection: a producer blocks a source only while its result
    // is further away than the consumer's use point. Register 0 never hazards.
    always_comb begin
        haz_rs_e = (hz.D_rs != 5'd0) && (e_dst_q == hz.D_rs) && (e_tnew_q > hz.D_rs_tuse);
        haz_rt_e = (hz.D_rt != 5'd0) && (e_dst_q == hz.D_rt) && (e_tnew_q > hz.D_rt_tuse);
        haz_rs_m = (hz.D_rs != 5'd0) && (m_dst_q == hz.D_rs) && (m_tnew_q > hz.D_rs_tuse);
        haz_rt_m = (hz.D_rt != 5'd0) && (m_dst_q == hz.D_rt) && (m_tnew_q > hz.D_rt_tuse);
        haz_md   = (hz.D_md_start || hz.D_md_use) && (md_cnt_q != '0);
        stall    = haz_rs_e || haz_rt_e || haz_rs_m || haz_rt_m || haz_md;
    end

    // Next state: bubble into E on stall, age E into M, run the mult/div
    // timer and the saturating stall counter.
    always_comb begin
        e_dst_d     = stall ? 5'd0 : hz.D_dst;
        e_tnew_d    = stall ? 2'd0 : hz.D_tnew;
        m_dst_d     = e_dst_q;
        m_tnew_d    = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!stall && hz.D_md_start) begin
            md_cnt_d = hz.D_md_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously so pause drops with reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q     <= '0;
            e_tnew_q    <= '0;
            m_dst_q     <= '0;
            m_tnew_q    <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_dst_q     <= e_dst_d;
            e_tnew_q    <= e_tnew_d;
            m_dst_q     <= m_dst_d;
            m_tnew_q    <= m_tnew_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pause     = stall;
    assign hz.E_flush   = stall;
    assign hz.md_busy   = (md_cnt_q != '0);
    assign hz.stall_cnt = stall_cnt_q;
endmodule
